// File: rtl/fetch_pkg.sv
// Shared types for the fetch prefetch queue: FSM states, PC increment and queue entry layout.
package fetch_pkg;

    typedef enum logic {
        S_RUN,
        S_DRAIN
    } state_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/pfq_fifo.sv
// Circular buffer of {pc, inst} entries with power-of-2 wrapping pointers and a flush.
module pfq_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [ENTRY_W-1:0]         push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output logic [ENTRY_W-1:0]         head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_pop;

    assign do_pop = pop && (count_q != '0);
    assign count  = count_q;
    assign head   = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= fetch_entry_t'(push_data);
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (!reset)
        !(push && !flush && !do_pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Sequential instruction prefetcher with credit-limited requests, redirect flush and drain.
// Optional combinational response bypass when built with PFQ_BYPASS_EN defined.
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    input  logic        inst_ready
);
    localparam int          CW           = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    state_t             state;
    state_t             state_nxt;
    logic [31:0]        fetch_pc;
    logic [31:0]        resp_pc;
    logic [31:0]        target_pc;
    logic [CW-1:0]      count;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      outstanding_nxt;
    logic [CW-1:0]      drop;
    logic [CW-1:0]      drop_nxt;
    logic               req_fire;
    logic               rsp_run;
    logic               push;
    logic               pop;
    logic               bypass_take;
    logic [ENTRY_W-1:0] head_raw;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;

    assign target_pc     = redirect_pc & ~32'h3;
    assign mem_req_addr  = fetch_pc;
    // Queued words plus in-flight requests may never exceed the queue size.
    assign mem_req_valid = reset && !redirect && (state == S_RUN) &&
                           (({1'b0, count} + {1'b0, outstanding}) < CREDIT_LIMIT);
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_run       = mem_rsp_valid && (state == S_RUN) && !redirect;
    assign head          = fetch_entry_t'(head_raw);
    assign push_entry    = '{pc: resp_pc, inst: mem_rsp_data};

`ifdef PFQ_BYPASS_EN
    logic bypass;
    assign bypass      = (count == '0) && (state == S_RUN) && mem_rsp_valid;
    assign inst_valid  = (count != '0) || bypass;
    assign inst        = bypass ? mem_rsp_data : head.inst;
    assign inst_pc     = bypass ? resp_pc : head.pc;
    assign bypass_take = bypass && inst_ready;
`else
    assign inst_valid  = (count != '0);
    assign inst        = head.inst;
    assign inst_pc     = head.pc;
    assign bypass_take = 1'b0;
`endif

    assign push            = rsp_run && !bypass_take;
    assign pop             = (count != '0) && inst_ready;
    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(mem_rsp_valid);

    pfq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (count),
        .head      (head_raw)
    );

    // A redirect leaves every still-unanswered request to be drained and thrown away.
    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        if (redirect) begin
            drop_nxt  = outstanding_nxt;
            state_nxt = (outstanding_nxt != '0) ? S_DRAIN : S_RUN;
        end else if ((state == S_DRAIN) && mem_rsp_valid) begin
            drop_nxt = drop - CW'(1);
            if (drop == CW'(1)) begin
                state_nxt = S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            state       <= state_nxt;
            drop        <= drop_nxt;
            outstanding <= outstanding_nxt;
            if (redirect) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (rsp_run) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed and randomized bench for fetch_prefetch_queue against an instruction-stream model
// with a variable-latency in-order memory.
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk           = 1'b0;
    logic        reset         = 1'b1;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data  = '0;
    logic        redirect      = 1'b0;
    logic [31:0] redirect_pc   = '0;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_ready    = 1'b0;

    always #5 clk = ~clk;

    fetch_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_pc       (inst_pc),
        .inst          (inst),
        .inst_ready    (inst_ready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] fire_log[$];
    logic [31:0] consumed_pc[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          epoch = 0;
    int          held = 0;
    int          last_due = 0;
    int          fire_cnt = 0;
    int          pop_cnt = 0;
    int          cfg_lat = 1;
    int          cfg_req_ready_pct = 100;
    int          cfg_inst_ready_pct = 100;
    int          cfg_redirect_pm = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] exp_req_addr = RESET_PC;
    logic        rsp_now = 1'b0;
    logic        prev_redirect = 1'b0;
    logic        pend_redirect = 1'b0;
    logic [31:0] pend_redirect_pc = '0;
    logic        redirect_on_rsp = 1'b0;

    // Memory contents are a fixed scramble of the address, so every word identifies its PC.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] random_target();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (t & 32'h0000_000F);
        else                           t = t & 32'h0000_FFFF;
        return t;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        check32(tag, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic applyStimulus();
        rsp_now       = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        mem_rsp_valid = rsp_now;
        mem_rsp_data  = rsp_now ? mem_word(mem_q[0].addr) : $urandom;
        mem_req_ready = ($urandom_range(0, 99) < cfg_req_ready_pct);
        inst_ready    = ($urandom_range(0, 99) < cfg_inst_ready_pct);
        redirect      = 1'b0;
        redirect_pc   = $urandom;
        if (!prev_redirect) begin
            if (pend_redirect && (!redirect_on_rsp || rsp_now)) begin
                redirect      = 1'b1;
                redirect_pc   = pend_redirect_pc;
                pend_redirect = 1'b0;
            end else if (!pend_redirect && ($urandom_range(0, 999) < cfg_redirect_pm)) begin
                redirect    = 1'b1;
                redirect_pc = random_target();
            end
        end
        prev_redirect = redirect;
    endtask

    task automatic checkOutput();
        int   inflight;
        logic old_pending;
        logic cur_arrival;
        logic exp_valid;
        logic took_arrival;
        inflight     = mem_q.size();
        old_pending  = 1'b0;
        took_arrival = 1'b0;
        for (int i = 0; i < mem_q.size(); i++) begin
            if (mem_q[i].epoch != epoch) old_pending = 1'b1;
        end
        cur_arrival = rsp_now && (mem_q[0].epoch == epoch);
        check1("mem_req_valid", mem_req_valid,
               !redirect && !old_pending && ((inflight + held) < DEPTH));
`ifdef PFQ_BYPASS_EN
        exp_valid = (held > 0) || cur_arrival;
`else
        exp_valid = (held > 0);
`endif
        check1("inst_valid", inst_valid, exp_valid);
        if (mem_req_valid && mem_req_ready) begin
            check32("mem_req_addr", mem_req_addr, exp_req_addr);
            last_due = (cyc + cfg_lat > last_due + 1) ? cyc + cfg_lat : last_due + 1;
            mem_q.push_back('{addr: mem_req_addr, due: last_due, epoch: epoch});
            fire_log.push_back(mem_req_addr);
            exp_req_addr += 32'd4;
            fire_cnt++;
        end
        if (inst_valid && inst_ready) begin
            check32("inst_pc", inst_pc, exp_pc);
            check32("inst", inst, mem_word(exp_pc));
            consumed_pc.push_back(inst_pc);
            exp_pc += 32'd4;
            pop_cnt++;
            if (held > 0) held--;
            else          took_arrival = 1'b1;
        end
        if (rsp_now) begin
            void'(mem_q.pop_front());
            if (cur_arrival && !redirect && !took_arrival) held++;
        end
        if (redirect) begin
            held         = 0;
            epoch++;
            exp_pc       = redirect_pc & ~32'h3;
            exp_req_addr = redirect_pc & ~32'h3;
        end
    endtask

    task automatic step();
        @(negedge clk);
        applyStimulus();
        #1;
        checkOutput();
        cyc++;
    endtask

    task automatic clear_logs();
        fire_log.delete();
        consumed_pc.delete();
        fire_cnt = 0;
        pop_cnt  = 0;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        redirect      = 1'b0;
        inst_ready    = 1'b0;
        mem_q.delete();
        held          = 0;
        epoch++;
        last_due      = 0;
        exp_pc        = RESET_PC;
        exp_req_addr  = RESET_PC;
        prev_redirect = 1'b0;
        pend_redirect = 1'b0;
        redirect_on_rsp = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check1("rst_mem_req_valid", mem_req_valid, 1'b0);
        check1("rst_inst_valid", inst_valid, 1'b0);
        check32("rst_inst_pc", inst_pc, 32'h0);
        check32("rst_inst", inst, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        clear_logs();
    endtask

    task automatic set_cfg(input int lat, input int rq, input int ir, input int rd);
        cfg_lat            = lat;
        cfg_req_ready_pct  = rq;
        cfg_inst_ready_pct = ir;
        cfg_redirect_pm    = rd;
    endtask

    initial begin
        #1;
        // Streaming with a 1-cycle memory and an always-ready core.
        do_reset();
        set_cfg(1, 100, 100, 0);
        repeat (30) step();
        check32("stream_pc0", q_at(consumed_pc, 0), 32'h0);
        check32("stream_pc1", q_at(consumed_pc, 1), 32'h4);
        check32("stream_pc2", q_at(consumed_pc, 2), 32'h8);

        // Core stalled: the queue fills to DEPTH and fetching stops.
        do_reset();
        set_cfg(1, 100, 0, 0);
        repeat (20) step();
        check32("stall_fires", fire_cnt, DEPTH);
        check1("stall_req_valid", mem_req_valid, 1'b0);
        clear_logs();
        set_cfg(1, 100, 100, 0);
        repeat (4) step();
        check32("release_pops", pop_cnt, 4);
        repeat (6) step();
        check32("resume_addr", q_at(fire_log, 0), 32'h10);

        // Redirect with three slow requests in flight.
        do_reset();
        set_cfg(5, 100, 100, 0);
        repeat (3) step();
        pend_redirect    = 1'b1;
        pend_redirect_pc = 32'h0000_0100;
        step();
        clear_logs();
        repeat (20) step();
        check32("drain_first_fire", q_at(fire_log, 0), 32'h100);
        check32("drain_first_pc", q_at(consumed_pc, 0), 32'h100);

        // Redirect landing on a cycle with a response arriving.
        do_reset();
        set_cfg(2, 100, 50, 0);
        repeat (6) step();
        pend_redirect    = 1'b1;
        pend_redirect_pc = 32'h0000_0200;
        redirect_on_rsp  = 1'b1;
        for (int n = 0; n < 50 && pend_redirect; n++) step();
        check1("rsp_redirect_taken", pend_redirect, 1'b0);
        redirect_on_rsp = 1'b0;
        clear_logs();
        cfg_inst_ready_pct = 100;
        repeat (20) step();
        check32("rsp_redirect_pc", q_at(consumed_pc, 0), 32'h200);

        // Redirect to the top of the address space, misaligned low bits masked.
        set_cfg(2, 100, 100, 0);
        pend_redirect    = 1'b1;
        pend_redirect_pc = 32'hFFFF_FFFD;
        for (int n = 0; n < 10 && pend_redirect; n++) step();
        clear_logs();
        repeat (20) step();
        check32("wrap_fire1", q_at(fire_log, 1), 32'h0);
        check32("wrap_pc0", q_at(consumed_pc, 0), 32'hFFFF_FFFC);
        check32("wrap_pc1", q_at(consumed_pc, 1), 32'h0);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        set_cfg(6, 100, 100, 0);
        repeat (3) step();
        pend_redirect    = 1'b1;
        pend_redirect_pc = 32'h0000_0300;
        repeat (3) step();
        check1("middrain_req_valid", mem_req_valid, 1'b0);
        @(negedge clk);
        #2;
        reset         = 1'b0;
        mem_rsp_valid = 1'b0;
        redirect      = 1'b0;
        #1;
        check1("async_mem_req_valid", mem_req_valid, 1'b0);
        check1("async_inst_valid", inst_valid, 1'b0);
        check32("async_inst_pc", inst_pc, 32'h0);
        check32("async_inst", inst, 32'h0);
        do_reset();
        set_cfg(1, 100, 100, 0);
        repeat (15) step();
        check32("restart_fire", q_at(fire_log, 0), RESET_PC);
        check32("restart_pc", q_at(consumed_pc, 0), RESET_PC);

        // Randomized traffic with occasional redirects.
        do_reset();
        for (int blk = 0; blk < 15; blk++) begin
            set_cfg($urandom_range(1, 6), $urandom_range(30, 100), $urandom_range(20, 100), 20);
            repeat (100) step();
        end
        check1("random_progress", pop_cnt > 100, 1'b1);

        $display("[TB] done after %0d cycles", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
